// File: rtl/flip_flop_jk.sv
// ---------------------------------------------------------------------------
// flip_flop_jk
//   Rising-edge JK flip-flop, WIDTH independent bits, with complementary output.
//   Each bit holds, resets, sets or toggles according to its own J/K pair.
//
// Parameters
//   WIDTH        number of independent JK bits (>= 1)
//   RESET_VALUE  value loaded into Q while rst_n is low at a rising edge
//
// Ports
//   clk    clock; all state changes on its rising edge
//   rst_n  synchronous active-low reset, has priority over J/K
//   J      per-bit set/toggle control
//   K      per-bit reset/toggle control
//   Q      registered state
//   QN     bitwise complement of Q
// ---------------------------------------------------------------------------
module flip_flop_jk #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    logic [WIDTH-1:0] q_next_c;

    // Characteristic equation: a bit becomes 1 when J sets/toggles it from 0,
    // or when it is already 1 and K does not clear/toggle it.
    always_comb begin
        q_next_c = (J & ~Q) | (~K & Q);
    end

    // State register; reset wins over J/K on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= q_next_c;
        end
    end

    // Complement derived directly from the register so it can never diverge.
    assign QN = ~Q;

endmodule

// File: tb/tb_flip_flop_jk.sv
// ---------------------------------------------------------------------------
// tb_flip_flop_jk
//   Self-checking bench for flip_flop_jk. Three instances (WIDTH 1, 4, 8) share
//   clock, reset and the low bits of one J/K stimulus pair. Expected values come
//   from directed constants and from a per-bit rule-table model.
// ---------------------------------------------------------------------------
module tb_flip_flop_jk;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] j8;
    logic [7:0] k8;

    logic [0:0] q1, qn1;
    logic [3:0] q4, qn4;
    logic [7:0] q8, qn8;

    // Model state for each instance, zero-extended to 8 bits.
    logic [7:0] em1, em4, em8;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] RV4 = 4'b1010;
    localparam logic [7:0] RV8 = 8'h5C;

    always #5 clk = ~clk;

    flip_flop_jk #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .J(j8[0:0]), .K(k8[0:0]), .Q(q1), .QN(qn1)
    );
    flip_flop_jk #(.WIDTH(4), .RESET_VALUE(RV4)) u4 (
        .clk(clk), .rst_n(rst_n), .J(j8[3:0]), .K(k8[3:0]), .Q(q4), .QN(qn4)
    );
    flip_flop_jk #(.WIDTH(8), .RESET_VALUE(RV8)) u8 (
        .clk(clk), .rst_n(rst_n), .J(j8), .K(k8), .Q(q8), .QN(qn8)
    );

    // Reference: apply the JK truth table bit by bit.
    function automatic logic [7:0] jk_model(input logic [7:0] q, input logic [7:0] j,
                                            input logic [7:0] k, input logic rst,
                                            input logic [7:0] rv, input int w);
        logic [7:0] r;
        r = 8'h00;
        if (!rst) return rv;
        for (int i = 0; i < w; i++) begin
            if (j[i] && k[i])      r[i] = ~q[i];
            else if (j[i])         r[i] = 1'b1;
            else if (k[i])         r[i] = 1'b0;
            else                   r[i] = q[i];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " q1"},  {7'b0, q1},  em1);
        check({tag, " qn1"}, {7'b0, qn1}, {7'b0, ~em1[0]});
        check({tag, " q4"},  {4'b0, q4},  em4);
        check({tag, " qn4"}, {4'b0, qn4}, {4'b0, ~em4[3:0]});
        check({tag, " q8"},  q8,          em8);
        check({tag, " qn8"}, qn8,         ~em8);
    endtask

    // One clock edge: advance the models with the inputs in effect, then compare.
    task automatic tick(input string tag);
        logic [7:0] n1, n4, n8;
        n1 = jk_model(em1, j8, k8, rst_n, 8'h00, 1);
        n4 = jk_model(em4, j8, k8, rst_n, {4'b0, RV4}, 4);
        n8 = jk_model(em8, j8, k8, rst_n, RV8, 8);
        @(posedge clk);
        #1;
        em1 = n1;
        em4 = n4;
        em8 = n8;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic [7:0] j, input logic [7:0] k);
        rst_n = r;
        j8    = j;
        k8    = k;
    endtask

    initial begin
        em1 = 'x;
        em4 = 'x;
        em8 = 'x;

        // Timed sequence on the 1-bit cell: inputs every 12 ns, edges at 5,15,...
        rst_n = 1'b1;
        fork
            begin
                j8 = 8'hFF; k8 = 8'h00;
                #12 j8 = 8'h00; k8 = 8'h00;
                #12 j8 = 8'h00; k8 = 8'hFF;
                #12 j8 = 8'hFF; k8 = 8'h00;
                #12 j8 = 8'hFF; k8 = 8'hFF;
            end
            begin
                #6  check("t5 set q",     {7'b0, q1}, 8'h01); check("t5 qn",  {7'b0, qn1}, 8'h00);
                #10 check("t15 hold q",   {7'b0, q1}, 8'h01); check("t15 qn", {7'b0, qn1}, 8'h00);
                #10 check("t25 reset q",  {7'b0, q1}, 8'h00); check("t25 qn", {7'b0, qn1}, 8'h01);
                #10 check("t35 reset q",  {7'b0, q1}, 8'h00); check("t35 qn", {7'b0, qn1}, 8'h01);
                #10 check("t45 set q",    {7'b0, q1}, 8'h01); check("t45 qn", {7'b0, qn1}, 8'h00);
                #10 check("t55 toggle q", {7'b0, q1}, 8'h00); check("t55 qn", {7'b0, qn1}, 8'h01);
            end
        join
        em1 = 8'h00;

        // Bring every instance to a known state.
        drive(1'b0, 8'h00, 8'h00); tick("init reset");
        check("rst q4",  {4'b0, q4},  8'h0A);
        check("rst qn4", {4'b0, qn4}, 8'h05);

        // Reset priority over a set request.
        drive(1'b1, 8'hFF, 8'h00); tick("prio set");
        check("prio set q1", {7'b0, q1}, 8'h01);
        drive(1'b0, 8'hFF, 8'h00); tick("prio rst");
        check("prio rst q1",  {7'b0, q1},  8'h00);
        check("prio rst qn1", {7'b0, qn1}, 8'h01);
        drive(1'b1, 8'hFF, 8'h00); tick("prio release");
        check("prio release q1", {7'b0, q1}, 8'h01);

        // Continuous toggle from reset: 1,0,1,0.
        drive(1'b0, 8'h00, 8'h00); tick("tog reset");
        drive(1'b1, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            tick("tog run");
            check("tog seq q1", {7'b0, q1}, (i % 2 == 0) ? 8'h01 : 8'h00);
        end
        // Reset lands mid-sequence, toggling resumes from the reset value.
        tick("tog pre");
        check("tog pre q1", {7'b0, q1}, 8'h01);
        drive(1'b0, 8'hFF, 8'hFF); tick("tog mid rst");
        check("tog mid rst q1", {7'b0, q1}, 8'h00);
        check("tog mid rst q4", {4'b0, q4}, 8'h0A);
        drive(1'b1, 8'hFF, 8'hFF); tick("tog resume");
        check("tog resume q1", {7'b0, q1}, 8'h01);
        check("tog resume q4", {4'b0, q4}, 8'h05);

        // Hold with J/K pulsed between edges.
        drive(1'b1, 8'hFF, 8'h00); tick("hold set");
        drive(1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            #2 j8 = 8'hFF; k8 = 8'hFF;
            #2 check("hold mid q1", {7'b0, q1}, 8'h01);
            check("hold mid q8", q8, 8'hFF);
            #2 j8 = 8'h00; k8 = 8'h00;
            tick("hold edge");
            check("hold edge q1", {7'b0, q1}, 8'h01);
        end

        // 4-bit per-bit rule: toggle, set, reset, hold from 1010 -> 1011.
        drive(1'b0, 8'h00, 8'h00); tick("w4 reset");
        check("w4 reset q",  {4'b0, q4},  8'h0A);
        check("w4 reset qn", {4'b0, qn4}, 8'h05);
        drive(1'b1, 8'h03, 8'h05); tick("w4 mix");
        check("w4 mix q",  {4'b0, q4},  8'h0B);
        check("w4 mix qn", {4'b0, qn4}, 8'h04);

        // Random stimulus against the model, occasional reset.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 15) != 0, 8'($urandom), 8'($urandom));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
